lock_range_sweeper: RTL and testbench
=====================================

Name: lock_range_sweeper

Overview:
- Automated lock-range measurement stage for the ADPLL bench. It sits upstream of the phase accumulator, driving its K value, and downstream of the ADPLL, consuming its signed phase error.
- It steps K from a start value to a stop value. At each step it resets the ADPLL, lets it settle, and checks the error magnitude on every reference edge.
- It reports the first contiguous locked K interval (lo/hi) for display.

Parameters:
- ACCUM_WIDTH, 12, width of the K value driven to the phase accumulator.
- ERR_WIDTH, 8, width of the signed ADPLL error input.
- LOCK_THRESH, 4, max |error| counted as in-lock (inclusive).
- PLL_RST_CYCLES, 16, clocks that pll_reset_o is held high at each step.
- SETTLE_CYCLES, 4096, clocks waited after the ADPLL reset before measuring.
- MEAS_EDGES, 256, reference rising edges checked per step.
- MEAS_TIMEOUT, 65536, clocks allowed for MEAS_EDGES edges before the step is declared unlocked.

Ports:
- fpga_clk_i  in  1  fast fabric clock (same domain as the ADPLL and phase accumulator).
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start pulse; honoured only in IDLE or DONE.
- k_start_i  in  ACCUM_WIDTH  first K value.
- k_stop_i  in  ACCUM_WIDTH  last K value (inclusive).
- k_step_i  in  ACCUM_WIDTH  K increment; 0 is treated as 1.
- ref_clk_i  in  1  reference clock from the phase accumulator, sampled synchronously.
- error_i  in  ERR_WIDTH  signed ADPLL phase error.
- k_val_o  out  ACCUM_WIDTH  K value to the phase accumulator.
- pll_reset_o  out  1  active-high reset to the ADPLL.
- lock_o  out  1  result of the most recent step.
- range_lo_o  out  ACCUM_WIDTH  first locked K.
- range_hi_o  out  ACCUM_WIDTH  last locked K of the first contiguous run.
- range_valid_o  out  1  at least one locked K was found.
- busy_o  out  1  sweep in progress.
- done_o  out  1  sweep finished; held until the next start.

Behaviour:
- Reset values: all outputs 0, except pll_reset_o = 1; FSM state is IDLE.
- Ref edge detection: ref_clk_i is registered once; a rising edge is prev = 0 and cur = 1. error_i is sampled in the same cycle the edge is detected.
- Error magnitude: computed at ERR_WIDTH+1 bits, so -128 gives 128 with no wrap. A sample is in-lock iff magnitude <= LOCK_THRESH.
- IDLE/DONE:
  - On start_i: latch k_start/k_stop/k_step, k_val_o <= k_start_i.
  - Clear range_lo/hi/valid, lock_o and done_o; set busy_o.
  - Go to PLL_RST.
- PLL_RST: pll_reset_o = 1 for PLL_RST_CYCLES clocks, then go to SETTLE. pll_reset_o is 0 in every other state except IDLE and DONE.
- SETTLE: wait SETTLE_CYCLES clocks, then go to MEASURE with the edge counter, timeout counter and fail flag cleared.
- MEASURE:
  - Each ref edge increments the edge counter; an out-of-lock sample sets the fail flag.
  - Exit when the edge counter reaches MEAS_EDGES: locked = !fail.
  - Exit when the timeout counter reaches MEAS_TIMEOUT: locked = 0.
  - Early-exit option: the first failing sample exits immediately with locked = 0.
  - Go to RECORD.
- RECORD (1 cycle):
  - lock_o <= locked.
  - If locked and !range_valid: range_lo <= k, range_hi <= k, range_valid <= 1.
  - Else if locked and the run is still open: range_hi <= k.
  - If !locked and range_valid: close the run, then go to DONE (end of the first run).
  - Otherwise go to STEP.
- STEP (1 cycle):
  - next = k + max(k_step, 1), computed at ACCUM_WIDTH+1 bits.
  - If next > k_stop or next overflows: go to DONE.
  - Else k_val_o <= next[ACCUM_WIDTH-1:0] and go to PLL_RST.
- DONE: busy_o = 0, done_o = 1, pll_reset_o = 1 (PLL held); k_val_o keeps its last value.
- k_start_i > k_stop_i: exactly one step is measured at k_start, then DONE.
- start_i while busy: ignored.
- Asynchronous reset mid-sweep: returns to IDLE with reset values, outputs cleared immediately.
- Latency: each step takes PLL_RST_CYCLES + SETTLE_CYCLES + measure time + 2 clocks.

Decomposition:
- Shared package: FSM state enum (IDLE, PLL_RST, SETTLE, MEASURE, RECORD, STEP, DONE) and the default ACCUM_WIDTH/ERR_WIDTH constants shared with the ADPLL and the phase accumulator.
- One sub-module: lock_window_checker (edge detect, abs/threshold, edge/timeout counters, fail flag → meas_done/locked).

Test Plan:
- Model ADPLL error = 0 for K in 100..140, else ±50; sweep 0..400 step 10 → range_lo 100, range_hi 140, range_valid 1, done_o 1, sweep stops at K 150.
- error_i forced to -128 on every edge → every step unlocked (magnitude 128, no wrap), range_valid 0, done at last K.
- ref_clk_i held low → each step ends after MEAS_TIMEOUT clocks with lock_o 0; total step time checked.
- k_start 4090, k_stop 4095, k_step 8 → one step at 4090, no overflow, done_o 1; k_step 0 → steps by 1, 6 steps.
- start_i pulsed mid-sweep is ignored; rst_n_i asserted in MEASURE → all outputs 0, pll_reset_o 1 asynchronously, IDLE.
- Single spike of +5 (LOCK_THRESH+1) within an otherwise 0 window → that K unlocked; +4 → locked.

Source files
------------

// File: rtl/lock_range_sweeper_pkg.sv
// Shared types and default widths for the lock-range sweeper, the ADPLL and the phase accumulator.
package lock_range_sweeper_pkg;

    localparam int DEFAULT_ACCUM_WIDTH = 12;
    localparam int DEFAULT_ERR_WIDTH   = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_PLL_RST = 3'd1;
    localparam state_t ST_SETTLE  = 3'd2;
    localparam state_t ST_MEASURE = 3'd3;
    localparam state_t ST_RECORD  = 3'd4;
    localparam state_t ST_STEP    = 3'd5;
    localparam state_t ST_DONE    = 3'd6;

endpackage

// File: rtl/lock_range_sweeper_checker.sv
// Measurement window for one K step: ref edge detect, |error| threshold, edge/timeout counting.
module lock_window_checker
    import lock_range_sweeper_pkg::*;
#(
    parameter int ERR_WIDTH    = DEFAULT_ERR_WIDTH,
    parameter int LOCK_THRESH  = 4,
    parameter int MEAS_EDGES   = 256,
    parameter int MEAS_TIMEOUT = 65536,
    parameter bit EARLY_EXIT   = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        ref_clk,
    input  logic signed [ERR_WIDTH-1:0] error,
    output logic                        meas_done,
    output logic                        locked
);

    localparam int EW = $clog2(MEAS_EDGES + 1);
    localparam int TW = $clog2(MEAS_TIMEOUT + 1);
    localparam logic [EW-1:0]        EDGE_LAST    = EW'(MEAS_EDGES - 1);
    localparam logic [TW-1:0]        TIMEOUT_LAST = TW'(MEAS_TIMEOUT - 1);
    localparam logic [ERR_WIDTH:0]   THRESH_VAL   = (ERR_WIDTH + 1)'(LOCK_THRESH);

    logic                 ref_prev_reg;
    logic [EW-1:0]        edge_cnt_reg;
    logic [TW-1:0]        timeout_reg;
    logic                 fail_reg;

    logic                 ref_edge;
    logic [ERR_WIDTH:0]   error_ext;
    logic [ERR_WIDTH:0]   magnitude;
    logic                 sample_fail;
    logic                 edges_done;
    logic                 timed_out;
    logic                 early_fail;

    assign ref_edge  = enable && !ref_prev_reg && ref_clk;

    // One extra bit so the most negative error maps to a positive magnitude.
    assign error_ext = {error[ERR_WIDTH-1], error};
    assign magnitude = error_ext[ERR_WIDTH] ? (~error_ext + 1'b1) : error_ext;

    assign sample_fail = ref_edge && (magnitude > THRESH_VAL);
    assign edges_done  = ref_edge && (edge_cnt_reg == EDGE_LAST);
    assign timed_out   = enable && (timeout_reg == TIMEOUT_LAST);
    assign early_fail  = EARLY_EXIT && sample_fail;

    // A final edge landing on the timeout cycle still counts as a completed window.
    assign meas_done = enable && (edges_done || timed_out || early_fail);
    assign locked    = edges_done && !(fail_reg || sample_fail);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_prev_reg <= 1'b0;
        end else begin
            ref_prev_reg <= ref_clk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_reg <= '0;
            timeout_reg  <= '0;
            fail_reg     <= 1'b0;
        end else if (!enable) begin
            edge_cnt_reg <= '0;
            timeout_reg  <= '0;
            fail_reg     <= 1'b0;
        end else begin
            timeout_reg <= timeout_reg + 1'b1;
            if (ref_edge) begin
                edge_cnt_reg <= edge_cnt_reg + 1'b1;
            end
            if (sample_fail) begin
                fail_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_range_sweeper.sv
// Steps K across a range, resets and settles the ADPLL at each step, and reports the first locked K run.
module lock_range_sweeper
    import lock_range_sweeper_pkg::*;
#(
    parameter int ACCUM_WIDTH    = DEFAULT_ACCUM_WIDTH,
    parameter int ERR_WIDTH      = DEFAULT_ERR_WIDTH,
    parameter int LOCK_THRESH    = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int SETTLE_CYCLES  = 4096,
    parameter int MEAS_EDGES     = 256,
    parameter int MEAS_TIMEOUT   = 65536,
    parameter bit EARLY_EXIT     = 1'b0
) (
    input  logic                        fpga_clk_i,
    input  logic                        rst_n_i,
    input  logic                        start_i,
    input  logic [ACCUM_WIDTH-1:0]      k_start_i,
    input  logic [ACCUM_WIDTH-1:0]      k_stop_i,
    input  logic [ACCUM_WIDTH-1:0]      k_step_i,
    input  logic                        ref_clk_i,
    input  logic signed [ERR_WIDTH-1:0] error_i,
    output logic [ACCUM_WIDTH-1:0]      k_val_o,
    output logic                        pll_reset_o,
    output logic                        lock_o,
    output logic [ACCUM_WIDTH-1:0]      range_lo_o,
    output logic [ACCUM_WIDTH-1:0]      range_hi_o,
    output logic                        range_valid_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int CYC_MAX = (PLL_RST_CYCLES > SETTLE_CYCLES) ? PLL_RST_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CYC_MAX + 1);
    localparam logic [CW-1:0]          RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0]          SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [ACCUM_WIDTH-1:0] STEP_ONE    = ACCUM_WIDTH'(1);

    state_t                 state_reg;
    logic [CW-1:0]          cnt_reg;
    logic [ACCUM_WIDTH-1:0] k_reg;
    logic [ACCUM_WIDTH-1:0] k_stop_reg;
    logic [ACCUM_WIDTH-1:0] k_step_reg;
    logic                   meas_locked_reg;
    logic                   lock_reg;
    logic [ACCUM_WIDTH-1:0] range_lo_reg;
    logic [ACCUM_WIDTH-1:0] range_hi_reg;
    logic                   range_valid_reg;
    logic                   run_open_reg;

    logic                   meas_enable;
    logic                   meas_done;
    logic                   meas_locked;
    logic [ACCUM_WIDTH:0]   step_sum;

    assign meas_enable = (state_reg == ST_MEASURE);
    // Carry bit catches wrap past the top of the K range.
    assign step_sum    = {1'b0, k_reg} + {1'b0, k_step_reg};

    lock_window_checker #(
        .ERR_WIDTH    (ERR_WIDTH),
        .LOCK_THRESH  (LOCK_THRESH),
        .MEAS_EDGES   (MEAS_EDGES),
        .MEAS_TIMEOUT (MEAS_TIMEOUT),
        .EARLY_EXIT   (EARLY_EXIT)
    ) u_checker (
        .clk       (fpga_clk_i),
        .rst_n     (rst_n_i),
        .enable    (meas_enable),
        .ref_clk   (ref_clk_i),
        .error     (error_i),
        .meas_done (meas_done),
        .locked    (meas_locked)
    );

    always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            k_reg           <= '0;
            k_stop_reg      <= '0;
            k_step_reg      <= '0;
            meas_locked_reg <= 1'b0;
            lock_reg        <= 1'b0;
            range_lo_reg    <= '0;
            range_hi_reg    <= '0;
            range_valid_reg <= 1'b0;
            run_open_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        k_reg           <= k_start_i;
                        k_stop_reg      <= k_stop_i;
                        k_step_reg      <= (k_step_i == '0) ? STEP_ONE : k_step_i;
                        lock_reg        <= 1'b0;
                        range_lo_reg    <= '0;
                        range_hi_reg    <= '0;
                        range_valid_reg <= 1'b0;
                        run_open_reg    <= 1'b0;
                        cnt_reg         <= '0;
                        state_reg       <= ST_PLL_RST;
                    end
                end
                ST_PLL_RST: begin
                    if (cnt_reg == RST_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_SETTLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_MEASURE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (meas_done) begin
                        meas_locked_reg <= meas_locked;
                        state_reg       <= ST_RECORD;
                    end
                end
                ST_RECORD: begin
                    lock_reg <= meas_locked_reg;
                    if (meas_locked_reg && !range_valid_reg) begin
                        range_lo_reg    <= k_reg;
                        range_hi_reg    <= k_reg;
                        range_valid_reg <= 1'b1;
                        run_open_reg    <= 1'b1;
                    end else if (meas_locked_reg && run_open_reg) begin
                        range_hi_reg <= k_reg;
                    end
                    // Only the first contiguous run is reported, so its end finishes the sweep.
                    if (!meas_locked_reg && range_valid_reg) begin
                        run_open_reg <= 1'b0;
                        state_reg    <= ST_DONE;
                    end else begin
                        state_reg <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (step_sum[ACCUM_WIDTH] || (step_sum[ACCUM_WIDTH-1:0] > k_stop_reg)) begin
                        state_reg <= ST_DONE;
                    end else begin
                        k_reg     <= step_sum[ACCUM_WIDTH-1:0];
                        cnt_reg   <= '0;
                        state_reg <= ST_PLL_RST;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign k_val_o       = k_reg;
    assign pll_reset_o   = (state_reg == ST_IDLE) || (state_reg == ST_PLL_RST) || (state_reg == ST_DONE);
    assign lock_o        = lock_reg;
    assign range_lo_o    = range_lo_reg;
    assign range_hi_o    = range_hi_reg;
    assign range_valid_o = range_valid_reg;
    assign busy_o        = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done_o        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_lock_range_sweeper.sv
// Directed bench for lock_range_sweeper: an ADPLL error model drives the sweep and a sweep-level model predicts results.
module tb_lock_range_sweeper;

    localparam int AW = 12;
    localparam int EW = 8;
    localparam int TH = 4;
    localparam int PR = 4;
    localparam int ST = 8;
    localparam int ME = 8;
    localparam int MT = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] k_start = '0;
    logic [AW-1:0] k_stop = '0;
    logic [AW-1:0] k_step = '0;
    logic          ref_clk = 1'b0;
    logic [EW-1:0] err = '0;
    logic [AW-1:0] k_val_o;
    logic          pll_reset_o;
    logic          lock_o;
    logic [AW-1:0] range_lo_o;
    logic [AW-1:0] range_hi_o;
    logic          range_valid_o;
    logic          busy_o;
    logic          done_o;

    lock_range_sweeper #(
        .ACCUM_WIDTH(AW), .ERR_WIDTH(EW), .LOCK_THRESH(TH), .PLL_RST_CYCLES(PR),
        .SETTLE_CYCLES(ST), .MEAS_EDGES(ME), .MEAS_TIMEOUT(MT), .EARLY_EXIT(1'b0)
    ) dut (
        .fpga_clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .k_start_i(k_start), .k_stop_i(k_stop), .k_step_i(k_step),
        .ref_clk_i(ref_clk), .error_i(err),
        .k_val_o(k_val_o), .pll_reset_o(pll_reset_o), .lock_o(lock_o),
        .range_lo_o(range_lo_o), .range_hi_o(range_hi_o), .range_valid_o(range_valid_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ADPLL stand-in: 0 window, constant -128, single spike, always zero.
    int mode = 0;
    int spike_k = 0;
    int spike_val = 0;
    bit ref_en = 1'b1;

    function automatic int err_at(input int k, input int edge_no);
        case (mode)
            0:       return (k >= 100 && k <= 140) ? 0 : ((k % 20 == 0) ? 50 : -50);
            1:       return -128;
            2:       return (k == spike_k && edge_no == 6) ? spike_val : 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_locked(input int k);
        int a;
        a = (spike_val < 0) ? -spike_val : spike_val;
        case (mode)
            0:       return (k >= 100 && k <= 140);
            1:       return 1'b0;
            2:       return (k == spike_k) ? (a <= TH) : 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    // Reference clock at 1/4 of fpga_clk; error presented with each rising edge.
    initial begin
        int div;
        int edge_no;
        div = 0;
        edge_no = 0;
        forever begin
            @(negedge clk);
            if (pll_reset_o) edge_no = 0;
            div++;
            if (div == 2) begin
                div = 0;
                if (ref_en) begin
                    ref_clk = ~ref_clk;
                    if (ref_clk) begin
                        edge_no++;
                        err = EW'(err_at(int'(k_val_o), edge_no));
                    end
                end else begin
                    ref_clk = 1'b0;
                end
            end
        end
    end

    // Sweep-level model: visited K list, per-K lock, first locked run.
    int exp_k[$];
    bit exp_lock[$];
    int exp_lo;
    int exp_hi;
    bit exp_valid;

    task automatic build_model(input int ks, input int ke, input int st);
        int k;
        int stp;
        bit lk;
        bit go;
        exp_k.delete();
        exp_lock.delete();
        exp_lo = 0;
        exp_hi = 0;
        exp_valid = 1'b0;
        k = ks;
        stp = (st == 0) ? 1 : st;
        go = 1'b1;
        while (go) begin
            lk = model_locked(k);
            exp_k.push_back(k);
            exp_lock.push_back(lk);
            if (lk && !exp_valid) begin
                exp_lo = k;
                exp_hi = k;
                exp_valid = 1'b1;
            end else if (lk) begin
                exp_hi = k;
            end
            if (!lk && exp_valid) go = 1'b0;
            else if (k + stp > ke || k + stp > (1 << AW) - 1) go = 1'b0;
            else k = k + stp;
        end
    endtask

    // Per-cycle compare: K follows the model sequence, lock_o reports each finished step.
    bit mon_en = 1'b0;
    int mon_idx = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mon_idx + 1 < exp_k.size() && int'(k_val_o) == exp_k[mon_idx + 1]) begin
                chk("lock_at_step", {31'd0, lock_o}, {31'd0, exp_lock[mon_idx]});
                mon_idx++;
            end
            chk("k_val", {20'd0, k_val_o}, exp_k[mon_idx]);
            if (busy_o) chk("done_while_busy", {31'd0, done_o}, 32'd0);
            else if (done_o) chk("pll_held_in_done", {31'd0, pll_reset_o}, 32'd1);
        end
    end

    task automatic run_sweep(input string name, input int ks, input int ke, input int st,
                             input int glitch_at, output int busy_cycles);
        int c;
        build_model(ks, ke, st);
        k_start = AW'(ks);
        k_stop  = AW'(ke);
        k_step  = AW'(st);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mon_idx = 0;
        mon_en = 1'b1;
        busy_cycles = busy_o ? 1 : 0;
        for (c = 0; c < 20000 && !done_o; c++) begin
            @(negedge clk);
            if (glitch_at > 0 && c == glitch_at) begin
                start = 1'b1;
                k_start = 12'd777;
            end else begin
                start = 1'b0;
            end
            if (busy_o) busy_cycles++;
        end
        mon_en = 1'b0;
        chk({name, "_done"}, {31'd0, done_o}, 32'd1);
        chk({name, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({name, "_last_k"}, {20'd0, k_val_o}, exp_k[exp_k.size() - 1]);
        chk({name, "_last_lock"}, {31'd0, lock_o}, {31'd0, exp_lock[exp_lock.size() - 1]});
        chk({name, "_steps"}, mon_idx + 1, exp_k.size());
        chk({name, "_valid"}, {31'd0, range_valid_o}, {31'd0, exp_valid});
        chk({name, "_lo"}, {20'd0, range_lo_o}, exp_lo);
        chk({name, "_hi"}, {20'd0, range_hi_o}, exp_hi);
        $display("sweep %s: K %0d..%0d step %0d -> lo %0d hi %0d valid %0d last K %0d steps %0d busy %0d",
                 name, ks, ke, st, range_lo_o, range_hi_o, range_valid_o, k_val_o, mon_idx + 1, busy_cycles);
    endtask

    initial begin
        int bc;
        int c;
        repeat (3) @(negedge clk);
        chk("rst_pll_reset", {31'd0, pll_reset_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_k", {20'd0, k_val_o}, 32'd0);
        chk("idle_outputs", {lock_o, range_valid_o, busy_o, done_o, pll_reset_o}, 32'b00001);
        chk("idle_range", {range_lo_o, range_hi_o}, 32'd0);

        // Locked window 100..140, with an ignored start pulse mid-sweep.
        mode = 0;
        run_sweep("window", 0, 400, 10, 300, bc);
        chk("window_lo_lit", {20'd0, range_lo_o}, 32'd100);
        chk("window_hi_lit", {20'd0, range_hi_o}, 32'd140);
        chk("window_stop_lit", {20'd0, k_val_o}, 32'd150);

        // Most negative error must read as magnitude 128, never locked.
        mode = 1;
        run_sweep("neg128", 0, 30, 10, 0, bc);
        chk("neg128_valid_lit", {31'd0, range_valid_o}, 32'd0);
        chk("neg128_last_lit", {20'd0, k_val_o}, 32'd30);

        // No reference edges: every step ends on the timeout.
        ref_en = 1'b0;
        run_sweep("timeout", 0, 10, 10, 0, bc);
        chk("timeout_busy_cycles", bc, exp_k.size() * (PR + ST + MT + 2));
        chk("timeout_busy_lit", bc, 32'd156);
        ref_en = 1'b1;

        // Top of the K range: no wrap, and zero step acts as one.
        mode = 3;
        run_sweep("overflow", 4090, 4095, 8, 0, bc);
        chk("overflow_k_lit", {20'd0, k_val_o}, 32'd4090);
        run_sweep("step0", 4090, 4095, 0, 0, bc);
        chk("step0_hi_lit", {20'd0, range_hi_o}, 32'd4095);
        run_sweep("reversed", 50, 20, 5, 0, bc);
        chk("reversed_k_lit", {20'd0, k_val_o}, 32'd50);

        // Threshold boundary: +5 breaks lock, +4 keeps it.
        mode = 2;
        spike_k = 210;
        spike_val = TH + 1;
        run_sweep("spike5", 200, 220, 10, 0, bc);
        chk("spike5_hi_lit", {20'd0, range_hi_o}, 32'd200);
        spike_val = TH;
        run_sweep("spike4", 200, 220, 10, 0, bc);
        chk("spike4_hi_lit", {20'd0, range_hi_o}, 32'd220);

        // Asynchronous reset while measuring.
        mode = 3;
        k_start = 12'd0;
        k_stop = 12'd100;
        k_step = 12'd10;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < 200 && pll_reset_o; c++) @(negedge clk);
        chk("settle_reached", {31'd0, pll_reset_o}, 32'd0);
        repeat (ST + 6) @(negedge clk);
        chk("busy_before_reset", {31'd0, busy_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {lock_o, range_valid_o, busy_o, done_o, pll_reset_o}, 32'b00001);
        chk("async_rst_k", {20'd0, k_val_o}, 32'd0);
        chk("async_rst_range", {range_lo_o, range_hi_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", {busy_o, done_o, pll_reset_o}, 32'b001);
        $display("reset mid-measure: busy %0d done %0d pll_reset %0d k %0d", busy_o, done_o, pll_reset_o, k_val_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
